maxunpool_stream: RTL

- Streaming 2x2 max-unpooling (upsample) block; the inverse of the 6x6→3x3 2x2 max-pool stage.
- Accepts pooled values and their 2-bit argmax index, one window per handshake, in raster order.
- Emits the 2H x 2W reconstructed feature map in raster order. Each value is placed at its argmax position and the other three pixels of its window are zero.
- Sits on the decoder/backward path, downstream of the pooled feature buffer.

---
 rtl/maxunpool_stream_if.sv | 25 ++
 rtl/maxunpool_stream.sv | 107 ++++++++++
 2 files changed

// File: rtl/maxunpool_stream_if.sv
// Handshake bundle for the 2x2 max-unpool stream: pooled entries in, unpooled pixels out.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface maxunpool_stream_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_idx;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              fsm_state;  // 0 = FILL, 1 = EMIT

  modport master (
    output in_valid, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_last, fsm_state
  );

  modport slave (
    input  in_valid, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_last, fsm_state
  );
endinterface

// File: rtl/maxunpool_stream.sv
// Streaming 2x2 max-unpooling: buffers one pooled row, then emits the two
// reconstructed output rows with each value at its argmax position.
module maxunpool_stream #(
  parameter int DATA_W = 16,
  parameter int IN_W   = 3,
  parameter int IN_H   = 3
) (
  input logic               clk,
  input logic               rst,
  maxunpool_stream_if.slave bus
);
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int PW = $clog2(4 * IN_W);
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     wcnt;
  logic [PW-1:0]     pcnt;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] rbuf_data [IN_W];
  logic [1:0]        rbuf_idx  [IN_W];

  logic              wr_en, fill_done, out_fire, row_done;
  logic [PW-1:0]     sel, sel_c;
  logic              sel_r, pix_last;
  logic [DATA_W-1:0] pix, data_v;
  logic [1:0]        idx_v;

  assign bus.fsm_state = state;

  always_comb begin
    state_nxt    = state;
    bus.in_ready = (state == FILL) && !rst;
    wr_en        = bus.in_valid && bus.in_ready;
    fill_done    = wr_en && (wcnt == CW'(IN_W - 1));
    out_fire     = bus.out_valid && bus.out_ready;
    row_done     = out_fire && (pcnt == PW'(4 * IN_W - 1));
    case (state)
      FILL:    if (fill_done) state_nxt = EMIT;
      EMIT:    if (row_done)  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Next pixel to load into the output register. The buffer view bypasses the
  // entry being written so the first pixel is correct even if its window is the last one.
  always_comb begin
    sel    = (state == FILL) ? '0 : pcnt + 1'b1;
    sel_r  = (sel >= PW'(2 * IN_W));
    sel_c  = sel_r ? sel - PW'(2 * IN_W) : sel;
    pix    = '0;
    data_v = '0;
    idx_v  = '0;
    for (int i = 0; i < IN_W; i++) begin
      if ((sel_c >> 1) == PW'(i)) begin
        data_v = (wr_en && wcnt == CW'(i)) ? bus.in_data : rbuf_data[i];
        idx_v  = (wr_en && wcnt == CW'(i)) ? bus.in_idx  : rbuf_idx[i];
        if (idx_v == {sel_r, sel_c[0]}) pix = data_v;
      end
    end
    pix_last = (row == RW'(IN_H - 1)) && (sel == PW'(4 * IN_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt          <= '0;
      pcnt          <= '0;
      row           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      if (wr_en) wcnt <= fill_done ? '0 : wcnt + 1'b1;
      if (fill_done) begin
        pcnt          <= '0;
        bus.out_valid <= 1'b1;
        bus.out_data  <= pix;
        bus.out_last  <= pix_last;
      end else if (row_done) begin
        bus.out_valid <= 1'b0;
        bus.out_data  <= '0;
        bus.out_last  <= 1'b0;
        row           <= (row == RW'(IN_H - 1)) ? '0 : row + 1'b1;
      end else if (out_fire) begin
        pcnt          <= pcnt + 1'b1;
        bus.out_data  <= pix;
        bus.out_last  <= pix_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_W; i++) begin
      if (wr_en && wcnt == CW'(i)) begin
        rbuf_data[i] <= bus.in_data;
        rbuf_idx[i]  <= bus.in_idx;
      end
    end
  end
endmodule
